// File: rtl/matmul_sp_reader.sv
// rtl/matmul_sp_reader.sv - APB read master packing a scratchpad result matrix into data_sp
// Optional per-transfer read timeout: define SP_RD_TIMEOUT_EN.
module matmul_sp_reader #(
    parameter int BUS_WIDTH   = 16,
    parameter int MAX_DIM     = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int SP_NTARGETS = 4,
    parameter int RD_TIMEOUT  = 255
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  start_i,
    input  logic [$clog2(SP_NTARGETS)-1:0]        sp_bank_i,
    input  logic [$clog2(MAX_DIM):0]              rows_i,
    input  logic [$clog2(MAX_DIM):0]              cols_i,
    output logic                                  psel_o,
    output logic                                  penable_o,
    output logic                                  pwrite_o,
    output logic [ADDR_WIDTH-1:0]                 paddr_o,
    input  logic [BUS_WIDTH-1:0]                  prdata_i,
    input  logic                                  pready_i,
    input  logic                                  pslverr_i,
    output logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0]  data_sp_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  err_o
);
    localparam int BANK_W   = $clog2(SP_NTARGETS);
    localparam int DIM_W    = $clog2(MAX_DIM) + 1;
    localparam int SLOT_W   = ADDR_WIDTH - 5;
    localparam int ROW_BITS = BUS_WIDTH * MAX_DIM;
    localparam logic [DIM_W-1:0] MAX_DIM_V = DIM_W'(MAX_DIM);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t                               state_q;
    logic [BANK_W-1:0]                    bank_q;
    logic [DIM_W-1:0]                     rows_q, cols_q, i_q, j_q;
    logic [ADDR_WIDTH-1:0]                paddr_q;
    logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0] data_q;
    logic                                 psel_q, penable_q, busy_q, done_q, err_q;

    logic [DIM_W-1:0]                     rows_d, cols_d, i_d, j_d;
    logic                                 last_d;

`ifdef SP_RD_TIMEOUT_EN
    localparam int WAIT_W = $clog2(RD_TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_q;
`endif

    // Scratchpad word address of element (i,j) in bank b, tagged with the SP region code.
    function automatic logic [ADDR_WIDTH-1:0] sp_addr(input logic [BANK_W-1:0] b,
                                                      input logic [DIM_W-1:0] i,
                                                      input logic [DIM_W-1:0] j);
        int slot;
        slot = int'(b) * MAX_DIM * MAX_DIM + int'(i) * MAX_DIM + int'(j);
        return {SLOT_W'(slot), 5'b10000};
    endfunction

    always_comb begin
        rows_d = (rows_i > MAX_DIM_V) ? MAX_DIM_V : rows_i;
        cols_d = (cols_i > MAX_DIM_V) ? MAX_DIM_V : cols_i;
        last_d = (i_q == rows_q - 1'b1) && (j_q == cols_q - 1'b1);
        if (j_q == cols_q - 1'b1) begin
            j_d = '0;
            i_d = i_q + 1'b1;
        end else begin
            j_d = j_q + 1'b1;
            i_d = i_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            bank_q    <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            i_q       <= '0;
            j_q       <= '0;
            paddr_q   <= '0;
            data_q    <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef SP_RD_TIMEOUT_EN
            wait_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        bank_q  <= sp_bank_i;
                        rows_q  <= rows_d;
                        cols_q  <= cols_d;
                        i_q     <= '0;
                        j_q     <= '0;
                        data_q  <= '0;
                        err_q   <= 1'b0;
                        paddr_q <= sp_addr(sp_bank_i, '0, '0);
                        if (rows_d == '0 || cols_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= SETUP;
                            done_q    <= 1'b0;
                            busy_q    <= 1'b1;
                            psel_q    <= 1'b1;
                            penable_q <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
`ifdef SP_RD_TIMEOUT_EN
                    wait_q    <= '0;
`endif
                end
                ACCESS: begin
                    if (pready_i) begin
                        // Data is kept even when the slave flags an error.
                        data_q[int'(i_q)*ROW_BITS + int'(j_q)*BUS_WIDTH +: BUS_WIDTH] <= prdata_i;
                        err_q     <= err_q | pslverr_i;
                        i_q       <= i_d;
                        j_q       <= j_d;
                        penable_q <= 1'b0;
                        if (last_d) begin
                            state_q <= DONE;
                            psel_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SETUP;
                            paddr_q <= sp_addr(bank_q, i_d, j_d);
                        end
                    end
`ifdef SP_RD_TIMEOUT_EN
                    else if (wait_q == WAIT_W'(RD_TIMEOUT)) begin
                        err_q     <= 1'b1;
                        state_q   <= DONE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwrite_o  = 1'b0;
    assign paddr_o   = paddr_q;
    assign data_sp_o = data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
endmodule

// File: tb/tb_matmul_sp_reader.sv
// tb/tb_matmul_sp_reader.sv - self-checking bench for matmul_sp_reader
// Exercises the SP_RD_TIMEOUT_EN case only when that macro is defined.
module tb_matmul_sp_reader;
`ifdef SP_RD_TIMEOUT_EN
    localparam int TB_TO = 8;
`else
    localparam int TB_TO = 255;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         start_i = 1'b0;
    logic [1:0]   sp_bank_i = '0;
    logic [2:0]   rows_i = '0;
    logic [2:0]   cols_i = '0;
    logic         psel_o, penable_o, pwrite_o;
    logic [15:0]  paddr_o;
    logic [15:0]  prdata_i = '0;
    logic         pready_i = 1'b0;
    logic         pslverr_i = 1'b0;
    logic [255:0] data_sp_o;
    logic         busy_o, done_o, err_o;

    matmul_sp_reader #(
        .BUS_WIDTH(16), .MAX_DIM(4), .ADDR_WIDTH(16), .SP_NTARGETS(4), .RD_TIMEOUT(TB_TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .sp_bank_i(sp_bank_i),
        .rows_i(rows_i), .cols_i(cols_i), .psel_o(psel_o), .penable_o(penable_o),
        .pwrite_o(pwrite_o), .paddr_o(paddr_o), .prdata_i(prdata_i), .pready_i(pready_i),
        .pslverr_i(pslverr_i), .data_sp_o(data_sp_o), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int failed = 0;

    // Scratchpad contents and slave behaviour knobs
    logic [15:0] sp_mem [0:63];
    int cfg_waits = 0;
    int cfg_err = -1;
    int cfg_stuck = -1;
    int acc_cnt = 0;
    int busy_bad = 0;
    logic [15:0] addr_q [$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // APB slave model and bus monitor, evaluated away from the rising edge
    always @(negedge clk_i) begin
        int slot;
        if (psel_o && !penable_o) addr_q.push_back(paddr_o);
        if (busy_o !== psel_o || pwrite_o !== 1'b0) busy_bad++;
        if (psel_o && penable_o) begin
            slot      = int'(paddr_o >> 5) & 63;
            pready_i  = (acc_cnt >= cfg_waits) && (slot != cfg_stuck);
            prdata_i  = sp_mem[slot];
            pslverr_i = (slot == cfg_err);
            acc_cnt++;
        end else begin
            acc_cnt   = 0;
            pready_i  = 1'b0;
            prdata_i  = '0;
            pslverr_i = 1'b0;
        end
    end

    task automatic kick(input int bank, input int rows, input int cols);
        @(negedge clk_i);
        sp_bank_i = 2'(bank);
        rows_i    = 3'(rows);
        cols_i    = 3'(cols);
        start_i   = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    // Returns the cycle number (start edge = edge 0) at which done_o is first seen high.
    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk_i);
            if (done_o) begin
                dcyc = n;
                break;
            end
        end
        if (dcyc < 0) begin
            tests++;
            failed++;
            $display("FAIL done_timeout: done_o never rose within 400 cycles");
        end
    endtask

    task automatic run(input string tag, input int bank, input int rin, input int cin,
                       input int waits, input int err_slot, input int exp_done, input logic exp_err);
        int r, c, dcyc, n;
        logic [255:0] exp_data;
        logic [15:0] exp_addr [$];
        r = (rin > 4) ? 4 : rin;
        c = (cin > 4) ? 4 : cin;
        exp_data = '0;
        for (int i = 0; i < r; i++)
            for (int j = 0; j < c; j++) begin
                exp_data[i*64 + j*16 +: 16] = sp_mem[bank*16 + i*4 + j];
                exp_addr.push_back(16'(((bank*16 + i*4 + j) << 5) | 16));
            end
        cfg_waits = waits;
        cfg_err   = err_slot;
        cfg_stuck = -1;
        addr_q.delete();
        busy_bad = 0;
        kick(bank, rin, cin);
        wait_done(dcyc);
        chk({tag, ".done_cycle"}, 256'(dcyc), 256'(exp_done));
        chk({tag, ".data_sp"}, data_sp_o, exp_data);
        chk({tag, ".err"}, 256'(err_o), 256'(exp_err));
        chk({tag, ".busy"}, 256'(busy_o), 256'(0));
        chk({tag, ".addr_count"}, 256'(addr_q.size()), 256'(exp_addr.size()));
        n = (addr_q.size() < exp_addr.size()) ? addr_q.size() : exp_addr.size();
        for (int k = 0; k < n; k++) chk({tag, ".addr"}, 256'(addr_q[k]), 256'(exp_addr[k]));
        chk({tag, ".busy_eq_psel"}, 256'(busy_bad), 256'(0));
    endtask

    typedef struct {
        int          bank, rows, cols, waits, err_slot, exp_done;
        logic [15:0] exp_addr0;
        logic        exp_err;
    } vec_t;

    initial begin
        vec_t vecs [6];
        int dcyc, bank, r, c, w, es, rc, cc;
        logic [255:0] exp_data;

        vecs[0] = '{0, 2, 3, 0, -1, 13, 16'h0010, 1'b0};
        vecs[1] = '{2, 4, 4, 3, -1, 81, 16'h0410, 1'b0};
        vecs[2] = '{0, 0, 4, 0, -1,  1, 16'h0000, 1'b0};
        vecs[3] = '{1, 3, 3, 0, 21, 19, 16'h0210, 1'b1};
        vecs[4] = '{3, 7, 5, 0, -1, 33, 16'h0610, 1'b0};
        vecs[5] = '{1, 1, 1, 1, -1,  4, 16'h0210, 1'b0};

        for (int s = 0; s < 64; s++) sp_mem[s] = 16'($urandom);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) sp_mem[i*4 + j] = 16'(i*3 + j + 1);
        for (int s = 32; s < 48; s++) sp_mem[s] = 16'hFFFF;

        repeat (3) @(negedge clk_i);
        chk("reset_ctrl", 256'({psel_o, penable_o, pwrite_o, busy_o, done_o, err_o}), 256'(0));
        chk("reset_paddr", 256'(paddr_o), 256'(0));
        chk("reset_data", data_sp_o, '0);
        rst_i = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run($sformatf("vec%0d", v), vecs[v].bank, vecs[v].rows, vecs[v].cols,
                vecs[v].waits, vecs[v].err_slot, vecs[v].exp_done, vecs[v].exp_err);
            if (vecs[v].rows != 0 && vecs[v].cols != 0)
                chk($sformatf("vec%0d.addr0", v), 256'(addr_q.size() > 0 ? addr_q[0] : 16'hDEAD),
                    256'(vecs[v].exp_addr0));
            if (v == 0) chk("vec0.elem12", 256'(data_sp_o[1*64 + 2*16 +: 16]), 256'(6));
        end

        // Reset during the ACCESS phase of element (0,2)
        cfg_waits = 0; cfg_err = -1; cfg_stuck = -1;
        kick(1, 4, 4);
        repeat (6) @(negedge clk_i);
        chk("rst_mid.in_access", 256'({psel_o, penable_o, paddr_o}), 256'({2'b11, 16'h0250}));
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_mid.ctrl", 256'({psel_o, penable_o, pwrite_o, busy_o, done_o, err_o}), 256'(0));
        chk("rst_mid.paddr", 256'(paddr_o), 256'(0));
        chk("rst_mid.data", data_sp_o, '0);
        rst_i = 1'b0;
        run("after_rst", 3, 2, 2, 0, -1, 9, 1'b0);

`ifdef SP_RD_TIMEOUT_EN
        // Slave never answers element (0,1) of bank 0: ACCESS entered in cycle 4
        cfg_waits = 0; cfg_err = -1; cfg_stuck = 1;
        kick(0, 2, 2);
        wait_done(dcyc);
        exp_data = '0;
        exp_data[15:0] = sp_mem[0];
        chk("timeout.done_cycle", 256'(dcyc), 256'(13));
        chk("timeout.err", 256'(err_o), 256'(1));
        chk("timeout.psel", 256'(psel_o), 256'(0));
        chk("timeout.data", data_sp_o, exp_data);
        cfg_stuck = -1;
`endif

        // Randomised readouts against the model
        for (int s = 0; s < 64; s++) sp_mem[s] = 16'($urandom);
        for (int t = 0; t < 24; t++) begin
            bank = int'($urandom_range(0, 3));
            r    = int'($urandom_range(0, 7));
            c    = int'($urandom_range(0, 7));
            w    = int'($urandom_range(0, 2));
            es   = ($urandom_range(0, 1) == 1) ? bank*16 + int'($urandom_range(0, 15)) : -1;
            rc   = (r > 4) ? 4 : r;
            cc   = (c > 4) ? 4 : c;
            run($sformatf("rand%0d", t), bank, r, c, w, es,
                (rc == 0 || cc == 0) ? 1 : rc*cc*(w + 2) + 1,
                (es >= 0) && ((es % 16) / 4 < rc) && ((es % 4) < cc) && rc > 0 && cc > 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
